// File: rtl/cpu_step_pkg.sv
// Shared state and mode encodings for the CPU step controller.
package cpu_step_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BURST  = 2'd1,
      ST_RUN    = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_STEP  = 2'd0,
      MODE_BURST = 2'd1,
      MODE_RUN   = 2'd2
   } mode_t;

   // Mode button cycles STEP -> BURST -> RUN -> STEP; code 3 is never produced.
   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_STEP:  return MODE_BURST;
         MODE_BURST: return MODE_RUN;
         default:    return MODE_STEP;
      endcase
   endfunction

endpackage

// File: rtl/cpu_step_controller_if.sv
// Button/CPU-facing signal bundle of the step controller.
interface cpu_step_controller_if #(
   parameter int unsigned DIV_W = 24
);
   logic             step_pulse;
   logic             mode_pulse;
   logic             halt;
   logic [DIV_W-1:0] run_div;
   logic             cpu_en;
   logic [1:0]       mode;
   logic             busy;
   logic             halted;
   logic [31:0]      cycle_count;

   modport master (
      output step_pulse, mode_pulse, halt, run_div,
      input  cpu_en, mode, busy, halted, cycle_count
   );

   modport slave (
      input  step_pulse, mode_pulse, halt, run_div,
      output cpu_en, mode, busy, halted, cycle_count
   );
endinterface

// File: rtl/run_prescaler.sv
// RUN-mode down-counter: tick fires while enabled at zero, and the count reloads at that point.
module run_prescaler #(
   parameter int unsigned DIV_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIV_W-1:0] reload,
   input  logic             enable,
   output logic             tick
);
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] count;

   assign tick = enable && (count == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= reload;
      end else if (enable) begin
         if (count == '0) count <= reload;
         else             count <= count - ONE;
      end
   end
endmodule

// File: rtl/cpu_step_controller.sv
// Turns step/mode button pulses into the MIPS core's single-cycle clock-enable.
// Optional cpu_en pulse counter on cycle_count when CPU_CYCLE_COUNT_EN is defined.
module cpu_step_controller
   import cpu_step_pkg::*;
#(
   parameter int unsigned DIV_W     = 24,
   parameter int unsigned BURST_LEN = 8
) (
   input logic                   clk,
   input logic                   reset,
   cpu_step_controller_if.slave  bus
);
   localparam logic [7:0] BURST_INIT = 8'(BURST_LEN);

   state_t     state;
   mode_t      mode_q;
   logic [7:0] burst_cnt;
   logic       cpu_en_q;
   logic       busy_q;
   logic       halted_q;
   logic       pre_load;
   logic       pre_enable;
   logic       pre_tick;

   assign pre_load   = (state == ST_IDLE) && !bus.halt && bus.step_pulse && (mode_q == MODE_RUN);
   assign pre_enable = (state == ST_RUN);

   run_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .load   (pre_load),
      .reload (bus.run_div),
      .enable (pre_enable),
      .tick   (pre_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_STEP;
         burst_cnt <= '0;
         cpu_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cpu_en_q <= 1'b0;
               if (bus.halt) begin
                  state    <= ST_HALTED;
                  halted_q <= 1'b1;
               end else if (bus.step_pulse) begin
                  case (mode_q)
                     MODE_STEP: cpu_en_q <= 1'b1;
                     MODE_BURST: begin
                        state     <= ST_BURST;
                        burst_cnt <= BURST_INIT;
                        cpu_en_q  <= 1'b1;
                        busy_q    <= 1'b1;
                     end
                     MODE_RUN: begin
                        state  <= ST_RUN;
                        busy_q <= 1'b1;
                     end
                     default: ;
                  endcase
               end else if (bus.mode_pulse) begin
                  mode_q <= next_mode(mode_q);
               end
            end
            ST_BURST: begin
               // burst_cnt counts the pulse currently on cpu_en; 1 means this is the last.
               if (bus.halt) begin
                  state    <= ST_HALTED;
                  cpu_en_q <= 1'b0;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  burst_cnt <= burst_cnt - 8'd1;
                  if (burst_cnt == 8'd1) begin
                     state    <= ST_IDLE;
                     cpu_en_q <= 1'b0;
                     busy_q   <= 1'b0;
                  end else begin
                     cpu_en_q <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.halt) begin
                  state    <= ST_HALTED;
                  cpu_en_q <= 1'b0;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else if (bus.step_pulse || bus.mode_pulse) begin
                  state    <= ST_IDLE;
                  cpu_en_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else begin
                  cpu_en_q <= pre_tick;
               end
            end
            default: begin
               cpu_en_q <= 1'b0;
               busy_q   <= 1'b0;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cpu_en = cpu_en_q;
   assign bus.mode   = mode_q;
   assign bus.busy   = busy_q;
   assign bus.halted = halted_q;

`ifdef CPU_CYCLE_COUNT_EN
   logic [31:0] cycle_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         cycle_cnt <= '0;
      else if (cpu_en_q) cycle_cnt <= cycle_cnt + 32'd1;
   end

   assign bus.cycle_count = cycle_cnt;
`else
   assign bus.cycle_count = '0;
`endif
endmodule

// File: tb/tb_cpu_step_controller.sv
// Vector-table and scoreboard bench for cpu_step_controller (STEP, BURST, RUN, HALT, reset).
module tb_cpu_step_controller;
   localparam int unsigned DIV_W = 24;
   localparam int unsigned BURST = 8;

   typedef struct {
      logic       step;
      logic       modep;
      logic       halt;
      logic       en;
      logic [1:0] mode;
      logic       busy;
      logic       halted;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cpu_step_controller_if #(.DIV_W(DIV_W)) bus ();

   cpu_step_controller #(.DIV_W(DIV_W), .BURST_LEN(BURST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   vec_t        exp_q[$];
   string       tag_q[$];
   vec_t        tbl_a[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_cc  = '0;

   function automatic vec_t mk(input logic s, input logic m, input logic h, input logic en,
                               input logic [1:0] md, input logic b, input logic hl);
      vec_t v;
      v.step = s; v.modep = m; v.halt = h;
      v.en = en; v.mode = md; v.busy = b; v.halted = hl;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_check();
      vec_t  e;
      string t;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check({t, ".cpu_en"},      32'(bus.cpu_en),   32'(e.en));
         check({t, ".mode"},        32'(bus.mode),     32'(e.mode));
         check({t, ".busy"},        32'(bus.busy),     32'(e.busy));
         check({t, ".halted"},      32'(bus.halted),   32'(e.halted));
         check({t, ".cycle_count"}, bus.cycle_count,   exp_cc);
`ifdef CPU_CYCLE_COUNT_EN
         if (e.en) exp_cc = exp_cc + 32'd1;
`endif
      end
   endtask

   // Drive one clock of inputs; the outcome is checked at the next falling edge.
   task automatic tick(input vec_t v, input bit push, input string tag);
      @(negedge clk);
      pop_check();
      bus.step_pulse = v.step;
      bus.mode_pulse = v.modep;
      bus.halt       = v.halt;
      if (push) begin
         exp_q.push_back(v);
         tag_q.push_back(tag);
      end
   endtask

   task automatic drain();
      tick(mk(0,0,0,0,0,0,0), 1'b0, "");
   endtask

   task automatic do_reset(input string tag);
      #2;
      reset = 1'b1;
      bus.step_pulse = 1'b0;
      bus.mode_pulse = 1'b0;
      bus.halt       = 1'b0;
      #1;
      check({tag, ".rst_cpu_en"}, 32'(bus.cpu_en), 32'd0);
      check({tag, ".rst_mode"},   32'(bus.mode),   32'd0);
      check({tag, ".rst_busy"},   32'(bus.busy),   32'd0);
      check({tag, ".rst_halted"}, 32'(bus.halted), 32'd0);
      check({tag, ".rst_cc"},     bus.cycle_count, 32'd0);
      exp_q.delete();
      tag_q.delete();
      exp_cc = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int unsigned d;
      int unsigned e;
      bus.step_pulse = 1'b0;
      bus.mode_pulse = 1'b0;
      bus.halt       = 1'b0;
      bus.run_div    = 24'd3;

      // step, mode, halt -> expected cpu_en, mode, busy, halted one clk later
      tbl_a.push_back(mk(0,0,0, 0,2'd0,0,0));
      tbl_a.push_back(mk(1,0,0, 1,2'd0,0,0));
      tbl_a.push_back(mk(0,0,0, 0,2'd0,0,0));
      tbl_a.push_back(mk(1,1,0, 1,2'd0,0,0));
      tbl_a.push_back(mk(0,0,0, 0,2'd0,0,0));
      tbl_a.push_back(mk(0,1,0, 0,2'd1,0,0));
      tbl_a.push_back(mk(1,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(1,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,1,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,0, 0,2'd1,0,0));
      tbl_a.push_back(mk(0,1,0, 0,2'd2,0,0));
      tbl_a.push_back(mk(0,1,0, 0,2'd0,0,0));
      tbl_a.push_back(mk(0,1,0, 0,2'd1,0,0));
      tbl_a.push_back(mk(0,1,0, 0,2'd2,0,0));
      tbl_a.push_back(mk(0,1,0, 0,2'd0,0,0));
      tbl_a.push_back(mk(0,1,0, 0,2'd1,0,0));
      tbl_a.push_back(mk(1,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,0, 1,2'd1,1,0));
      tbl_a.push_back(mk(0,0,1, 0,2'd1,0,1));
      tbl_a.push_back(mk(1,0,0, 0,2'd1,0,1));
      tbl_a.push_back(mk(0,1,0, 0,2'd1,0,1));
      tbl_a.push_back(mk(0,0,0, 0,2'd1,0,1));

      do_reset("init");
      for (int i = 0; i < tbl_a.size(); i++)
         tick(tbl_a[i], 1'b1, $sformatf("tbl%0d", i));
      drain();

      // RUN mode: run_div=3 gives a pulse every 4 clks, then run_div=0 gives one every clk.
      do_reset("run");
      tick(mk(0,1,0, 0,2'd1,0,0), 1'b1, "run_m1");
      tick(mk(0,1,0, 0,2'd2,0,0), 1'b1, "run_m2");
      d = 3;
      bus.run_div = 24'(d);
      tick(mk(1,0,0, 0,2'd2,1,0), 1'b1, "run_entry");
      for (e = 1; e <= 20; e++)
         tick(mk(0,0,0, logic'((e % (d + 1)) == 0), 2'd2,1,0), 1'b1, $sformatf("run_d3_e%0d", e));
      tick(mk(1,0,0, 0,2'd2,0,0), 1'b1, "run_exit");
      for (int i = 0; i < 5; i++)
         tick(mk(0,0,0, 0,2'd2,0,0), 1'b1, $sformatf("run_idle%0d", i));
      bus.run_div = 24'd0;
      tick(mk(1,0,0, 0,2'd2,1,0), 1'b1, "run0_entry");
      for (int i = 1; i <= 4; i++)
         tick(mk(0,0,0, 1,2'd2,1,0), 1'b1, $sformatf("run0_e%0d", i));
      tick(mk(0,0,1, 0,2'd2,0,1), 1'b1, "run0_halt");
      tick(mk(1,1,0, 0,2'd2,0,1), 1'b1, "run0_halted1");
      tick(mk(0,0,0, 0,2'd2,0,1), 1'b1, "run0_halted2");
      drain();

      // Halt wins over a simultaneous step/mode press in IDLE.
      do_reset("hprio");
      tick(mk(1,1,1, 0,2'd0,0,1), 1'b1, "hprio_a");
      tick(mk(1,0,0, 0,2'd0,0,1), 1'b1, "hprio_b");
      drain();

      // Asynchronous reset while a burst is driving cpu_en.
      do_reset("mid");
      tick(mk(0,1,0, 0,2'd1,0,0), 1'b1, "mid_m1");
      tick(mk(1,0,0, 1,2'd1,1,0), 1'b1, "mid_b1");
      tick(mk(0,0,0, 1,2'd1,1,0), 1'b1, "mid_b2");
      drain();
      #2;
      check("mid_pre_cpu_en", 32'(bus.cpu_en), 32'd1);
      do_reset("mid_burst");

`ifdef CPU_CYCLE_COUNT_EN
      force dut.cycle_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_cnt;
      exp_cc = 32'hFFFF_FFFF;
      tick(mk(1,0,0, 1,2'd0,0,0), 1'b1, "wrap_step");
      tick(mk(0,0,0, 0,2'd0,0,0), 1'b1, "wrap_after");
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
Consumes one-cycle pulses from the debounced push-buttons and produces the single-cycle clock-enable that advances the MIPS core.
- Three user-selected modes: STEP (one CPU cycle per press), BURST (BURST_LEN cycles per press) and RUN (free-running at a programmable divided rate).
- A halt from the core freezes execution until reset.
- Sits between the button debouncers and the CPU datapath's clock-enable input.

Parameters:
- DIV_W, 24, width of the RUN-mode prescaler and of run_div.
- BURST_LEN, 8, CPU cycles emitted per press in BURST mode; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- step_pulse  in  1  one-cycle press pulse from the step-button debouncer.
- mode_pulse  in  1  one-cycle press pulse from the mode-button debouncer.
- halt  in  1  level from CPU (break/syscall exit); sampled every clk.
- run_div  in  DIV_W  RUN prescaler reload; a CPU cycle fires every run_div+1 clks.
- cpu_en  out  1  registered one-clk enable; one pulse equals one CPU cycle.
- mode  out  2  current mode: 0 STEP, 1 BURST, 2 RUN; value 3 is never produced.
- busy  out  1  high while in BURST or RUN.
- halted  out  1  high in HALTED.
- cycle_count  out  32  number of cpu_en pulses issued (see Optional Feature).

Behaviour:
- Reset (async, active-high): state IDLE, mode=0, cpu_en=0, busy=0, halted=0, cycle_count=0, prescaler and burst counters 0.
- All outputs are registered. Latency: the cycle in which a decision is sampled is t; cpu_en rises at t+1.
- IDLE:
  - halt=1 -> HALTED. Halt has priority over every pulse in the same cycle.
  - Else step_pulse=1:
    - mode STEP -> one cpu_en pulse at t+1; stay IDLE.
    - mode BURST -> BURST, load burst_cnt=BURST_LEN.
    - mode RUN -> RUN, load prescaler=run_div.
  - Else mode_pulse=1 -> mode advances 0->1->2->0.
  - step_pulse and mode_pulse in the same cycle: step_pulse acts using the current mode; mode_pulse is dropped.
- BURST:
  - cpu_en high on BURST_LEN consecutive clks starting at t+1; burst_cnt decrements per pulse.
  - On the last pulse, return to IDLE; busy drops in the following clk.
  - step_pulse and mode_pulse are ignored.
  - halt=1 -> HALTED immediately; no further cpu_en from that cycle on.
- RUN:
  - Prescaler decrements each clk. At 0: cpu_en pulse next clk, reload from run_div (sampled at reload time).
  - run_div=0 -> cpu_en high every clk.
  - The first pulse occurs run_div+1 clks after entry.
  - step_pulse or mode_pulse -> IDLE with no further cpu_en; mode is unchanged by that press.
  - halt -> HALTED.
- HALTED:
  - cpu_en=0, busy=0, halted=1.
  - Terminal state; only reset leaves it. All pulses are ignored.
- cpu_en is never high in the clk after the clk in which HALTED was entered.
- Reset mid-BURST or mid-RUN returns to the reset values immediately, including cpu_en=0 asynchronously.

Optional Feature:
- Macro: CPU_CYCLE_COUNT_EN.
- Defined: 32-bit cycle_count increments on every clk where cpu_en=1, wrapping 32'hFFFFFFFF->0; cleared only by reset.
- Undefined: no counter logic is synthesised; cycle_count is tied to 32'd0.

Decomposition:
- Shared package/header cpu_step_pkg:
  - State encodings ST_IDLE, ST_BURST, ST_RUN, ST_HALTED.
  - Mode codes MODE_STEP=2'd0, MODE_BURST=2'd1, MODE_RUN=2'd2.
- Sub-module run_prescaler:
  - Function: DIV_W down-counter with load, enable and a one-clk tick at zero-reload.
  - Interface: clk, reset, load, reload value, enable, tick.
  - Instantiated once for RUN mode.

Test Plan:
- Reset, mode=0, single step_pulse -> exactly one cpu_en pulse one clk later; busy stays 0; cycle_count=1.
- mode_pulse once, then step_pulse with BURST_LEN=8 -> cpu_en high 8 consecutive clks; busy high for those 8 clks; cycle_count=8; state returns to IDLE.
- mode_pulse x2, run_div=3, step_pulse -> cpu_en every 4th clk. After 5 pulses, step_pulse -> no further cpu_en; mode still 2.
- Halt during BURST after 3 pulses -> no further cpu_en; halted=1. Subsequent step_pulse/mode_pulse have no effect until reset.
- step_pulse and mode_pulse in the same clk in IDLE with mode=0 -> one cpu_en; mode stays 0. mode_pulse x3 -> mode wraps back to 0.
- With CPU_CYCLE_COUNT_EN: force counter to 32'hFFFFFFFF, one step -> cycle_count=0. Without the macro -> cycle_count=0 throughout all scenarios.
